mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle datapath's MAR/MDR memory interface.
- Accepts read and write requests that the controller issues through MemMode, with the address from MAR and write data from MDR.
- Performs the access after a fixed, parameterised latency and returns read data to MDR with a one-cycle ready strobe.
- Holds the instruction/data word store: single port, one access in flight at a time.

---
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word store answering MAR/MDR requests after LATENCY cycles, with a return-to-idle handshake.
// Optional MEM_BOUNDS_CHK_EN adds MemErr and suppresses accesses whose upper MARAddr bits are nonzero.
module mem_responder #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       MemMode,
  input  logic [WIDTH-1:0] MARAddr,
  input  logic [WIDTH-1:0] MDRIn,
  output logic [WIDTH-1:0] MemData,
  output logic             MemReady,
  output logic             MemBusy
`ifdef MEM_BOUNDS_CHK_EN
  ,
  output logic             MemErr
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]     data_q;
  logic                 err_q;
  logic                 req;
  logic                 finish;
  logic                 ready_nxt, busy_nxt, err_nxt;
  logic [WIDTH-1:0]     data_nxt;
  logic [WIDTH-1:0]     mem [DEPTH];

  assign req    = (MemMode == 2'b01) || (MemMode == 2'b10);
  assign finish = (state == WAIT) && (cnt == 4'd0);

`ifdef MEM_BOUNDS_CHK_EN
  logic addr_oob;
  assign addr_oob = |MARAddr[WIDTH-1:ADDR_BITS];
`else
  // Upper address bits alias onto the low ones when bounds checking is off.
  logic addr_oob;
  logic unused_addr_hi;
  assign unused_addr_hi = ^MARAddr[WIDTH-1:ADDR_BITS];
  assign addr_oob       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch: mode/address/data changes after acceptance are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      op_wr  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && req) begin
      cnt    <= LAT_M1;
      op_wr  <= MemMode[1];
      addr_q <= MARAddr[ADDR_BITS-1:0];
      data_q <= MDRIn;
      err_q  <= addr_oob;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    busy_nxt  = MemBusy;
    data_nxt  = MemData;
    if (state == IDLE && req) busy_nxt = 1'b1;
    if (state == DONE)        busy_nxt = 1'b0;
    if (finish) begin
      ready_nxt = 1'b1;
      err_nxt   = err_q;
      if (!op_wr) data_nxt = err_q ? '0 : mem[addr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemData  <= '0;
      MemReady <= 1'b0;
      MemBusy  <= 1'b0;
    end else begin
      MemData  <= data_nxt;
      MemReady <= ready_nxt;
      MemBusy  <= busy_nxt;
    end
  end

`ifdef MEM_BOUNDS_CHK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) MemErr <= 1'b0;
    else        MemErr <= err_nxt;
  end
`else
  logic unused_err;
  assign unused_err = err_nxt ^ err_q;
`endif

  // Storage is never reset; an aborted request cannot reach here since reset forces IDLE.
  always_ff @(posedge clk) begin
    if (finish && op_wr && !err_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: requests push expected responses, a negedge monitor checks them.
// Build with or without MEM_BOUNDS_CHK_EN; the reference model follows the same define.
module tb_mem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  typedef struct {
    logic [15:0] data;
    logic        is_rd;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  MemMode = 2'b00;
  logic [15:0] MARAddr = 16'h0;
  logic [15:0] MDRIn = 16'h0;
  wire  [15:0] MemData;
  wire         MemReady;
  wire         MemBusy;
`ifdef MEM_BOUNDS_CHK_EN
  wire         MemErr;
`endif

  mem_responder #(.WIDTH(16), .ADDR_BITS(8), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MemMode(MemMode), .MARAddr(MARAddr), .MDRIn(MDRIn),
    .MemData(MemData), .MemReady(MemReady), .MemBusy(MemBusy)
`ifdef MEM_BOUNDS_CHK_EN
    , .MemErr(MemErr)
`endif
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pulses = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] cur_data = 16'h0;
  exp_t        q[$];
  exp_t        mon_e;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per MemReady pulse, checks held data and busy window every cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (MemReady) begin
        pulses++;
        if (q.size() == 0) begin
          check("spurious_ready", MemReady, 0);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.is_rd) cur_data = mon_e.data;
          check("ready_cycle", cyc, mon_e.due);
`ifdef MEM_BOUNDS_CHK_EN
          check("err_with_ready", MemErr, mon_e.err);
`endif
        end
      end
`ifdef MEM_BOUNDS_CHK_EN
      else check("err_idle", MemErr, 0);
`endif
      check("data", MemData, cur_data);
      check("busy", MemBusy, (cyc >= busy_lo) && (cyc <= busy_hi));
    end
  end

  // Issue one request from a negedge with the DUT idle; return at a negedge with the DUT idle again.
  task automatic do_req(input logic [1:0] mode, input logic [15:0] addr, input logic [15:0] din,
                        input int hold, input bit perturb, input logic [1:0] p_mode,
                        input logic [15:0] p_addr);
    exp_t e;
    logic oob;
    int   idx;
    logic got;
    idx = int'(addr) % DEPTH;
    oob = 1'b0;
`ifdef MEM_BOUNDS_CHK_EN
    oob = (int'(addr) >= DEPTH);
`endif
    e.is_rd = (mode == 2'b01);
    e.err   = oob;
    e.due   = cyc + 1 + LAT;
    if (e.is_rd) begin
      e.data = oob ? 16'h0 : model[idx];
    end else begin
      e.data = 16'h0;
      if (!oob) model[idx] = din;
    end
    q.push_back(e);
    busy_lo = cyc + 1;
    busy_hi = cyc + 1 + LAT;
    MemMode = mode;
    MARAddr = addr;
    MDRIn   = din;
    got = 1'b0;
    for (int i = 0; i < LAT + 8 && !got; i++) begin
      @(negedge clk);
      got = MemReady;
      if (i == 0 && perturb && !got) begin
        MemMode = p_mode;
        MARAddr = p_addr;
        MDRIn   = 16'($urandom);
      end
    end
    if (!got) begin
      check("ready_timeout", got, 1);
      q.delete();
    end
    repeat (hold + 1) @(negedge clk);
    MemMode = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
    @(negedge clk);
    MemMode = 2'b00;
  endtask

  task automatic simple(input logic [1:0] mode, input logic [15:0] addr, input logic [15:0] din);
    do_req(mode, addr, din, 0, 1'b0, 2'b00, 16'h0);
  endtask

  initial begin
    int p0;
    logic [15:0] a;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_data", MemData, 0);
    check("rst_ready", MemReady, 0);
    check("rst_busy", MemBusy, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < DEPTH; i++) simple(2'b10, 16'(i), 16'($urandom));

    // Write then read back
    simple(2'b10, 16'h0012, 16'hBEEF);
    simple(2'b01, 16'h0012, 16'h0);
    check("rd_beef", MemData, 16'hBEEF);

    // Level-held request issues once per handshake
    p0 = pulses;
    do_req(2'b01, 16'h0003, 16'h0, 10, 1'b0, 2'b00, 16'h0);
    check("level_one_pulse", pulses - p0, 1);
    do_req(2'b01, 16'h0003, 16'h0, 0, 1'b0, 2'b00, 16'h0);
    check("level_second_pulse", pulses - p0, 2);

    // Changes during WAIT are ignored
    do_req(2'b01, 16'h0005, 16'h0, 0, 1'b1, 2'b10, 16'h0006);
    check("midop_rd5", MemData, model[5]);
    simple(2'b01, 16'h0006, 16'h0);
    check("midop_mem6", MemData, model[6]);

    // Reset while a write is waiting
    MemMode = 2'b10;
    MARAddr = 16'h0020;
    MDRIn   = 16'h1234;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_data", MemData, 0);
    check("midrst_ready", MemReady, 0);
    check("midrst_busy", MemBusy, 0);
    q.delete();
    cur_data = 16'h0;
    busy_lo = 1;
    busy_hi = 0;
    MemMode = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    simple(2'b01, 16'h0020, 16'h0);
    check("midrst_prior", MemData, model[32]);

    // Wrap / bounds
    simple(2'b10, 16'h0100, 16'hAAAA);
    simple(2'b01, 16'h0000, 16'h0);
`ifdef MEM_BOUNDS_CHK_EN
    check("oob_mem0_kept", MemData, model[0]);
    simple(2'b01, 16'h0100, 16'h0);
    check("oob_rd_zero", MemData, 0);
`else
    check("wrap_rd0", MemData, 16'hAAAA);
`endif

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(7) == 0) ? 16'($urandom) : 16'($urandom_range(255));
      do_req(($urandom_range(1) == 0) ? 2'b01 : 2'b10, a, 16'($urandom),
             $urandom_range(2), 1'b0, 2'b00, 16'h0);
      repeat ($urandom_range(2)) begin
        MemMode = ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
        @(negedge clk);
      end
      MemMode = 2'b00;
    end

    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
